ddr2_stub_responder: RTL and testbench

//  Single-clock, synthesizable responder for the DDR2 af/wdf/rdf FIFO protocol: sits where the
//  MIG controller plus its clock-crossing FIFOs sit and answers RequestController traffic from a block-RAM array.

---
 rtl/ddr2_stub_pkg.sv | 22 ++
 rtl/resp_sync_fifo.sv | 55 +++++
 rtl/ddr2_stub_responder.sv | 208 ++++++++++++++++++++
 tb/tb_ddr2_stub_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_stub_pkg.sv
// Shared definitions for the DDR2 stub responder: command codes, FIFO entry
// widths and the service FSM state type.
package ddr2_stub_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int AF_W  = 34;   // {cmd[2:0], addr[30:0]}
    localparam int WDF_W = 144;  // {mask[15:0], data[127:0]}
    localparam int RDF_W = 128;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_RLAT,
        ST_RD0,
        ST_RD1
    } state_t;

endpackage

// File: rtl/resp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// PUSH_WHEN_FULL=1 lets a push land in the same cycle a pop frees the slot.
module resp_sync_fifo #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int PUSH_WHEN_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || ((PUSH_WHEN_FULL != 0) && do_pop));
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // storage write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ddr2_stub_responder.sv
// Block-RAM backed stand-in for the MIG DDR2 controller and its af/wdf/rdf FIFOs.
// Optional protocol checker: define RESP_PROTOCOL_CHECK_EN to drive a sticky err.
//
//  state | meaning
//  INIT  | counting down power-up delay, FIFOs refuse traffic
//  IDLE  | inspect af head, start the next burst when its resources are ready
//  WR0   | merge write beat 0 into the beat-0 RAM
//  WR1   | merge write beat 1 into the beat-1 RAM (waits for the beat)
//  RLAT  | emulated read latency
//  RD0   | push beat 0 of the line into rdf
//  RD1   | push beat 1 of the line into rdf
module ddr2_stub_responder
    import ddr2_stub_pkg::*;
#(
    parameter int MEM_LINES_LOG2 = 10,
    parameter int AF_DEPTH       = 8,
    parameter int WDF_DEPTH      = 16,
    parameter int RDF_DEPTH      = 16,
    parameter int READ_LAT       = 4,
    parameter int INIT_CYCLES    = 16
) (
    input  logic         clk,
    input  logic         rst,
    output logic         init_done,
    input  logic         af_wr_en,
    input  logic [2:0]   af_cmd_din,
    input  logic [30:0]  af_addr_din,
    output logic         af_full,
    input  logic         wdf_wr_en,
    input  logic [127:0] wdf_din,
    input  logic [15:0]  wdf_mask_din,
    output logic         wdf_full,
    input  logic         rdf_rd_en,
    output logic         rdf_valid,
    output logic [127:0] rdf_dout,
    output logic         err
);
    localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
    localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;
    localparam int RDF_CW = $clog2(RDF_DEPTH) + 1;
    localparam int ICW    = $clog2(INIT_CYCLES + 1);
    localparam int LCW    = $clog2(READ_LAT + 1);
    localparam int LINES  = 2 ** MEM_LINES_LOG2;

    state_t                    state_q;
    logic [ICW-1:0]            init_cnt_q;
    logic [LCW-1:0]            lat_cnt_q;
    logic                      init_done_q;
    logic [MEM_LINES_LOG2-1:0] line_q;

    logic [AF_W-1:0]   af_dout;
    logic [WDF_W-1:0]  wdf_dout;
    logic [RDF_W-1:0]  rdf_head;
    logic [RDF_W-1:0]  rdf_din;
    logic [AF_CW-1:0]  af_count;
    logic [WDF_CW-1:0] wdf_count;
    logic [RDF_CW-1:0] rdf_count;
    logic af_push, wdf_push, af_pop, wdf_pop, rdf_push;
    logic af_nempty, wdf_nempty, rdf_room;
    logic [2:0]                af_cmd;
    logic [MEM_LINES_LOG2-1:0] af_line;
    logic [MEM_LINES_LOG2-1:0] rd_addr;

    logic [127:0] ram0_q [LINES];
    logic [127:0] ram1_q [LINES];
    logic [127:0] rd0_q;
    logic [127:0] rd1_q;

    // upper address bits alias onto the same line
    logic unused_addr_bits;
    assign unused_addr_bits = ^{af_dout[30:MEM_LINES_LOG2+2], af_dout[1:0]};

    assign af_cmd     = af_dout[33:31];
    assign af_line    = af_dout[MEM_LINES_LOG2+1:2];
    assign af_nempty  = (af_count != '0);
    assign wdf_nempty = (wdf_count != '0);
    // no read is in flight while in IDLE, so occupancy alone decides room
    assign rdf_room   = (rdf_count <= RDF_CW'(RDF_DEPTH - 2));

    assign af_full   = !init_done_q || (af_count == AF_CW'(AF_DEPTH));
    assign wdf_full  = !init_done_q || (wdf_count == WDF_CW'(WDF_DEPTH));
    assign af_push   = af_wr_en && init_done_q;
    assign wdf_push  = wdf_wr_en && init_done_q;
    assign init_done = init_done_q;
    assign rdf_valid = (rdf_count != '0);
    assign rdf_dout  = rdf_valid ? rdf_head : '0;

    resp_sync_fifo #(.WIDTH(AF_W), .DEPTH(AF_DEPTH), .PUSH_WHEN_FULL(0)) u_af (
        .clk(clk), .rst(rst), .push_i(af_push), .din_i({af_cmd_din, af_addr_din}),
        .pop_i(af_pop), .dout_o(af_dout), .count_o(af_count));

    resp_sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH), .PUSH_WHEN_FULL(0)) u_wdf (
        .clk(clk), .rst(rst), .push_i(wdf_push), .din_i({wdf_mask_din, wdf_din}),
        .pop_i(wdf_pop), .dout_o(wdf_dout), .count_o(wdf_count));

    resp_sync_fifo #(.WIDTH(RDF_W), .DEPTH(RDF_DEPTH), .PUSH_WHEN_FULL(1)) u_rdf (
        .clk(clk), .rst(rst), .push_i(rdf_push), .din_i(rdf_din),
        .pop_i(rdf_rd_en), .dout_o(rdf_head), .count_o(rdf_count));

    // FIFO handshakes derived from the current service state
    always_comb begin
        af_pop   = 1'b0;
        wdf_pop  = 1'b0;
        rdf_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (af_nempty) begin
                    if (af_cmd == CMD_WRITE)     af_pop = wdf_nempty;
                    else if (af_cmd == CMD_READ) af_pop = rdf_room;
                    else                         af_pop = 1'b1;
                end
            end
            ST_WR0, ST_WR1: wdf_pop  = wdf_nempty;
            ST_RD0, ST_RD1: rdf_push = 1'b1;
            default: ;
        endcase
    end

    // service FSM: init delay, command dispatch, burst sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= ICW'(INIT_CYCLES);
            init_done_q <= 1'b0;
            lat_cnt_q   <= '0;
            line_q      <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q <= ICW'(1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        init_cnt_q <= init_cnt_q - ICW'(1);
                    end
                end
                ST_IDLE: begin
                    if (af_pop) begin
                        line_q <= af_line;
                        if (af_cmd == CMD_WRITE) begin
                            state_q <= ST_WR0;
                        end else if (af_cmd == CMD_READ) begin
                            lat_cnt_q <= LCW'(READ_LAT - 1);
                            state_q   <= (READ_LAT > 1) ? ST_RLAT : ST_RD0;
                        end
                    end
                end
                ST_WR0:  if (wdf_pop) state_q <= ST_WR1;
                ST_WR1:  if (wdf_pop) state_q <= ST_IDLE;
                ST_RLAT: begin
                    if (lat_cnt_q <= LCW'(1)) state_q <= ST_RD0;
                    else                      lat_cnt_q <= lat_cnt_q - LCW'(1);
                end
                ST_RD0:  state_q <= ST_RD1;
                ST_RD1:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // byte-enable merge of the popped write beat into the selected RAM half
    always_ff @(posedge clk) begin
        if (!rst && wdf_pop) begin
            for (int b = 0; b < 16; b++) begin
                if (!wdf_dout[128 + b]) begin
                    if (state_q == ST_WR0) ram0_q[line_q][b*8 +: 8] <= wdf_dout[b*8 +: 8];
                    else                   ram1_q[line_q][b*8 +: 8] <= wdf_dout[b*8 +: 8];
                end
            end
        end
    end

    // synchronous read; IDLE looks at the af head so READ_LAT=1 still works
    assign rd_addr = (state_q == ST_IDLE) ? af_line : line_q;
    always_ff @(posedge clk) begin
        rd0_q <= ram0_q[rd_addr];
        rd1_q <= ram1_q[rd_addr];
    end
    assign rdf_din = (state_q == ST_RD1) ? rd1_q : rd0_q;

`ifdef RESP_PROTOCOL_CHECK_EN
    logic       err_q;
    logic [6:0] wdf_idle_q;
    logic       wr_pending;

    assign wr_pending = (af_nempty && (af_cmd == CMD_WRITE)) ||
                        (state_q == ST_WR0) || (state_q == ST_WR1);

    // sticky protocol error with a down-counter for orphaned write data
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            wdf_idle_q <= 7'd64;
        end else begin
            if (!wdf_nempty || wr_pending) wdf_idle_q <= 7'd64;
            else if (wdf_idle_q != 7'd0)   wdf_idle_q <= wdf_idle_q - 7'd1;
            if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full) ||
                (af_pop && (af_cmd != CMD_WRITE) && (af_cmd != CMD_READ)) ||
                (rdf_rd_en && !rdf_valid) || (wdf_idle_q == 7'd0))
                err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_stub_responder.sv
// Scoreboard bench for ddr2_stub_responder: read commands push expected beats,
// a monitor pops and compares every beat the DUT hands over.
module tb_ddr2_stub_responder;
    import ddr2_stub_pkg::*;

    localparam int READ_LAT    = 4;
    localparam int INIT_CYCLES = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_done;
    logic         af_wr_en = 1'b0;
    logic [2:0]   af_cmd_din = '0;
    logic [30:0]  af_addr_din = '0;
    logic         af_full;
    logic         wdf_wr_en = 1'b0;
    logic [127:0] wdf_din = '0;
    logic [15:0]  wdf_mask_din = '0;
    logic         wdf_full;
    logic         rdf_rd_en = 1'b0;
    logic         rdf_valid;
    logic [127:0] rdf_dout;
    logic         err;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           drain_en = 1'b0;
    logic [127:0] exp_q [$];
    logic [255:0] model [int];

    ddr2_stub_responder #(
        .MEM_LINES_LOG2(10), .AF_DEPTH(8), .WDF_DEPTH(16), .RDF_DEPTH(16),
        .READ_LAT(READ_LAT), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_full(af_full),
        .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_full(wdf_full),
        .rdf_rd_en(rdf_rd_en), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                           input logic [15:0] m);
        logic [127:0] r = old;
        for (int b = 0; b < 16; b++)
            if (!m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // monitor: decides the pop for the next edge and checks the beat it takes
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            rdf_rd_en = drain_en;
            if (!rst && drain_en && rdf_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got %h expected no beat", rdf_dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_beat", rdf_dout, e);
                end
            end
        end
    end

    // all push tasks start and end on a falling edge
    task automatic af_push(input logic [2:0] cmd, input logic [30:0] addr);
        int n = 0;
        while (af_full && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (af_full) timeout_fail("af_push");
        af_wr_en    = 1'b1;
        af_cmd_din  = cmd;
        af_addr_din = addr;
        @(negedge clk);
        af_wr_en = 1'b0;
    endtask

    task automatic wdf_push(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        while (wdf_full && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (wdf_full) timeout_fail("wdf_push");
        wdf_wr_en    = 1'b1;
        wdf_din      = d;
        wdf_mask_din = m;
        @(negedge clk);
        wdf_wr_en = 1'b0;
    endtask

    task automatic do_write(input logic [30:0] addr, input logic [127:0] d0, input logic [15:0] m0,
                            input logic [127:0] d1, input logic [15:0] m1);
        int line = int'(addr[11:2]);
        logic [255:0] old = model.exists(line) ? model[line] : '0;
        model[line] = {merge(old[255:128], d1, m1), merge(old[127:0], d0, m0)};
        af_push(CMD_WRITE, addr);
        wdf_push(d0, m0);
        wdf_push(d1, m1);
    endtask

    task automatic read_cmd(input logic [30:0] addr);
        int line = int'(addr[11:2]);
        logic [255:0] v = model[line];
        exp_q.push_back(v[127:0]);
        exp_q.push_back(v[255:128]);
        af_push(CMD_READ, addr);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic reset_and_init();
        int c = 0;
        rst       = 1'b1;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_af_full", af_full, 1);
        chk("rst_wdf_full", wdf_full, 1);
        chk("rst_rdf_valid", rdf_valid, 0);
        chk("rst_rdf_dout", rdf_dout, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        while (!init_done && c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (!init_done) chk("init_af_full_hold", af_full, 1);
        end
        chk("init_cycles", c, INIT_CYCLES);
        chk("init_af_full", af_full, 0);
        chk("init_wdf_full", wdf_full, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a_beat;
        logic [127:0] b_beat;
        int c;

        a_beat = {32{4'h1}};
        b_beat = {32{4'h2}};
        reset_and_init();
        drain_en = 1'b1;

        // basic write then read, with first-beat latency measured
        do_write(31'h40, a_beat, 16'h0000, b_beat, 16'h0000);
        repeat (10) @(negedge clk);
        read_cmd(31'h40);
        c = 0;
        while (!rdf_valid && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("read_latency", c, READ_LAT + 1);
        wait_drain();

        // masked rewrite of beat 0, beat 1 fully masked
        do_write(31'h40, {128{1'b1}}, 16'h00FF, 128'h0, 16'hFFFF);
        exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, a_beat[63:0]});
        exp_q.push_back(b_beat);
        af_push(CMD_READ, 31'h40);
        read_cmd(31'h1040);
        wait_drain();

        // backpressure: rdf fills, remaining reads stay in af
        for (int i = 0; i < 4; i++)
            do_write(31'h100 + 31'(4 * i), {4{32'hB000_0000 + 32'(i)}}, 16'h0000,
                     {4{32'hC000_0000 + 32'(i)}}, 16'h0000);
        drain_en = 1'b0;
        for (int k = 0; k < 10; k++) read_cmd(31'h100 + 31'(4 * (k % 4)));
        repeat (150) @(negedge clk);
        chk("bp_rdf_valid", rdf_valid, 1);
        chk("bp_af_not_full", af_full, 0);
        for (int k = 0; k < 6; k++) read_cmd(31'h10C - 31'(4 * (k % 4)));
        repeat (3) @(negedge clk);
        chk("bp_af_full", af_full, 1);
        drain_en = 1'b1;
        wait_drain();

        // write command ahead of its data blocks a following read
        model[int'(31'h200 >> 2)] = {{8{16'hD00D}}, {8{16'hBEEF}}};
        af_push(CMD_WRITE, 31'h200);
        read_cmd(31'h200);
        repeat (20) @(negedge clk);
        chk("read_blocked", rdf_valid, 0);
        wdf_push({8{16'hBEEF}}, 16'h0000);
        wdf_push({8{16'hD00D}}, 16'h0000);
        wait_drain();

        // reset during read latency
        repeat (10) @(negedge clk);
        af_push(CMD_READ, 31'h40);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_rdf_valid", rdf_valid, 0);
        chk("midrst_init_done", init_done, 0);
        reset_and_init();
        read_cmd(31'h40);
        read_cmd(31'h104);
        read_cmd(31'h200);
        wait_drain();

        chk("err_default", err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
